// File: rtl/div_result_bcd_pkg.sv
// Shared state encoding, default sizing and elaboration helpers for the
// divider result / BCD conversion stage.
package div_bcd_pkg;

  localparam logic [1:0] ST_WAIT = 2'b00;
  localparam logic [1:0] ST_CONV = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  localparam int DEF_BITSIZE = 8;
  localparam int DEF_DIGITS  = 3;
  localparam int DEF_CNTSIZE = 4;

  // Number of decimal digits needed for the largest BITSIZE-bit value (BITSIZE < 64).
  function automatic int min_digits(input int bitsize);
    logic [63:0] max_val;
    int          digits;
    max_val = (64'd1 << bitsize) - 64'd1;
    digits  = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      digits  = digits + 1;
    end
    return digits;
  endfunction

endpackage

// File: rtl/div_result_bcd_dabble_step.sv
// One double-dabble iteration: every BCD digit >= 5 gets +3 (mod 16), then
// the whole {BCD, binary} vector shifts left by one.
module bcd_dabble_step
  import div_bcd_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int DIGITS  = DEF_DIGITS
) (
  input  logic [4*DIGITS+BITSIZE-1:0] din,
  output logic [4*DIGITS+BITSIZE-1:0] dout
);

  localparam int W = 4*DIGITS + BITSIZE;

  logic [W-1:0] adj_s;

  assign adj_s[BITSIZE-1:0] = din[BITSIZE-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] digit_s;
    assign digit_s = din[BITSIZE+4*i +: 4];
    assign adj_s[BITSIZE+4*i +: 4] = (digit_s >= 4'd5) ? (digit_s + 4'd3) : digit_s;
  end

  assign dout = adj_s << 1'b1;

endmodule

// File: rtl/div_result_bcd.sv
// Captures a completed division, converts quotient and remainder to packed BCD
// sequentially, and holds the result for a valid/ack consumer.
module div_result_bcd
  import div_bcd_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int DIGITS  = DEF_DIGITS,
  parameter int CNTSIZE = DEF_CNTSIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_idle,
  input  logic                  div_not_valid,
  input  logic [BITSIZE-1:0]    quotient,
  input  logic [BITSIZE-1:0]    remainder,
  output logic [4*DIGITS-1:0]   bcd_quot,
  output logic [4*DIGITS-1:0]   bcd_rem,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic                  busy,
  output logic                  overrun
);

  localparam int W = 4*DIGITS + BITSIZE;
  localparam logic [CNTSIZE-1:0] CNT_LAST = CNTSIZE'(BITSIZE - 1);

  if (DIGITS < min_digits(BITSIZE)) begin : g_bad_digits
    $error("div_result_bcd: DIGITS too small for BITSIZE");
  end
  if (CNTSIZE < $clog2(BITSIZE) + 1) begin : g_bad_cntsize
    $error("div_result_bcd: CNTSIZE too small for BITSIZE");
  end

  logic [1:0]         state_r;
  logic               idle_d_r;
  logic [W-1:0]       qsh_r;
  logic [W-1:0]       rsh_r;
  logic [CNTSIZE-1:0] cnt_r;
  logic [W-1:0]       q_step_s;
  logic [W-1:0]       r_step_s;
  logic               rise_s;
  logic               capture_s;
  logic               drop_s;
  logic               last_s;

  // A completion is only accepted in WAIT, or in HOLD when the consumer acks on that edge.
  assign rise_s    = div_idle & ~idle_d_r;
  assign capture_s = rise_s & ((state_r == ST_WAIT) | ((state_r == ST_HOLD) & out_ack));
  assign drop_s    = rise_s & ~capture_s;
  assign last_s    = (cnt_r == CNT_LAST);
  assign busy      = (state_r != ST_WAIT);

  bcd_dabble_step #(.BITSIZE(BITSIZE), .DIGITS(DIGITS)) u_step_quot (
    .din  (qsh_r),
    .dout (q_step_s)
  );

  bcd_dabble_step #(.BITSIZE(BITSIZE), .DIGITS(DIGITS)) u_step_rem (
    .din  (rsh_r),
    .dout (r_step_s)
  );

  // Idle history; resets high so the post-reset idle level is not a completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_d_r <= 1'b1;
    end else begin
      idle_d_r <= div_idle;
    end
  end

  // Sticky drop flag, cleared by the next accepted completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (capture_s) begin
      overrun <= 1'b0;
    end else if (drop_s) begin
      overrun <= 1'b1;
    end else begin
      overrun <= overrun;
    end
  end

  // Control FSM, conversion shift registers and held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_WAIT;
      qsh_r     <= '0;
      rsh_r     <= '0;
      cnt_r     <= '0;
      bcd_quot  <= '0;
      bcd_rem   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else if (capture_s) begin
      if (div_not_valid) begin
        bcd_quot  <= '0;
        bcd_rem   <= '0;
        err       <= 1'b1;
        out_valid <= 1'b1;
        state_r   <= ST_HOLD;
      end else begin
        qsh_r     <= {{(4*DIGITS){1'b0}}, quotient};
        rsh_r     <= {{(4*DIGITS){1'b0}}, remainder};
        cnt_r     <= '0;
        out_valid <= 1'b0;
        state_r   <= ST_CONV;
      end
    end else begin
      case (state_r)
        ST_WAIT: begin
          state_r <= ST_WAIT;
        end
        ST_CONV: begin
          qsh_r <= q_step_s;
          rsh_r <= r_step_s;
          cnt_r <= cnt_r + 1'b1;
          if (last_s) begin
            bcd_quot  <= q_step_s[W-1:BITSIZE];
            bcd_rem   <= r_step_s[W-1:BITSIZE];
            err       <= 1'b0;
            out_valid <= 1'b1;
            state_r   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            state_r   <= ST_WAIT;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Scenario-driven bench for div_result_bcd with a queue scoreboard of expected BCD results.
module tb_div_result_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_idle = 1'b1;
  logic        div_not_valid = 1'b0;
  logic [7:0]  quotient = 8'd0;
  logic [7:0]  remainder = 8'd0;
  logic [11:0] bcd_quot;
  logic [11:0] bcd_rem;
  logic        err;
  logic        out_valid;
  logic        out_ack = 1'b0;
  logic        busy;
  logic        overrun;

  typedef struct packed {
    logic [11:0] q;
    logic [11:0] r;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  div_result_bcd dut (
    .clk           (clk),
    .rst           (rst),
    .div_idle      (div_idle),
    .div_not_valid (div_not_valid),
    .quotient      (quotient),
    .remainder     (remainder),
    .bcd_quot      (bcd_quot),
    .bcd_rem       (bcd_rem),
    .err           (err),
    .out_valid     (out_valid),
    .out_ack       (out_ack),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Divider finishes: idle drops for a cycle, then rises with stable results.
  // Returns 1 ns after the capture edge.
  task automatic fire(input int dividend, input int divisor, input bit push, input bit ack_same);
    int q;
    int r;
    bit nv;
    nv = (divisor == 0);
    q  = nv ? 170 : dividend / divisor;
    r  = nv ? 85  : dividend % divisor;
    div_idle = 1'b0;
    cycle();
    quotient      = q[7:0];
    remainder     = r[7:0];
    div_not_valid = nv;
    div_idle      = 1'b1;
    if (ack_same) out_ack = 1'b1;
    if (push) begin
      if (nv) sb.push_back(exp_t'{12'h000, 12'h000, 1'b1});
      else    sb.push_back(exp_t'{to_bcd(q), to_bcd(r), 1'b0});
    end
    cycle();
    out_ack = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    cycle();
    out_ack = 1'b0;
  endtask

  task automatic score(input string name, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 40) begin
      cycle();
      n++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%0b after %0d cycles, required 1", name, out_valid, n);
    end
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: queue size 0, required >0", name);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (n !== lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d, required %0d", name, n, lat);
    end
    n_checks++;
    if (bcd_quot !== e.q) begin
      n_fail++;
      $display("FAIL %s_quot: got %h, required %h", name, bcd_quot, e.q);
    end
    n_checks++;
    if (bcd_rem !== e.r) begin
      n_fail++;
      $display("FAIL %s_rem: got %h, required %h", name, bcd_rem, e.r);
    end
    n_checks++;
    if (err !== e.e) begin
      n_fail++;
      $display("FAIL %s_err: got %b, required %b", name, err, e.e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cycle();
    n_checks++;
    if ({bcd_quot, bcd_rem, err, out_valid, busy, overrun} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {bcd_quot, bcd_rem, err, out_valid, busy, overrun});
    end
    rst = 1'b0;
    repeat (5) cycle();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_level: busy got %b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    fire(255, 13, 1'b1, 1'b0);
    n_checks++;
    if ({busy, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_busy: busy/out_valid got %b, required 10", {busy, out_valid});
    end
    score("basic", 8);
    ack();
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_ack: out_valid/busy got %b, required 00", {out_valid, busy});
    end
  endtask

  task automatic test_extremes();
    fire(255, 1, 1'b1, 1'b0);
    score("max", 8);
    ack();
    fire(0, 7, 1'b1, 1'b0);
    score("zero", 8);
    ack();
  endtask

  task automatic test_div_zero();
    fire(77, 0, 1'b1, 1'b0);
    score("divzero", 0);
    repeat (10) cycle();
    n_checks++;
    if ({out_valid, err, bcd_quot, bcd_rem} !== 26'h3000000) begin
      n_fail++;
      $display("FAIL divzero_hold: got %h, required 3000000", {out_valid, err, bcd_quot, bcd_rem});
    end
    ack();
  endtask

  task automatic test_backpressure();
    fire(200, 7, 1'b1, 1'b0);
    score("bp_first", 8);
    fire(100, 3, 1'b0, 1'b0);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overrun_set: got %b, required 1", overrun);
    end
    repeat (10) cycle();
    n_checks++;
    if ({out_valid, bcd_quot, bcd_rem} !== {1'b1, to_bcd(28), to_bcd(4)}) begin
      n_fail++;
      $display("FAIL bp_hold: got %h, required %h", {out_valid, bcd_quot, bcd_rem}, {1'b1, to_bcd(28), to_bcd(4)});
    end
    ack();
    fire(100, 3, 1'b1, 1'b0);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_overrun_clear: got %b, required 0", overrun);
    end
    score("bp_third", 8);
    ack();
  endtask

  task automatic test_back_to_back();
    fire(123, 10, 1'b1, 1'b0);
    score("b2b_first", 8);
    fire(250, 9, 1'b1, 1'b1);
    n_checks++;
    if ({overrun, busy, out_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL b2b_capture: overrun/busy/out_valid got %b, required 010", {overrun, busy, out_valid});
    end
    score("b2b_second", 8);
    ack();
  endtask

  task automatic test_reset_mid();
    fire(45, 6, 1'b0, 1'b0);
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bcd_quot, bcd_rem, err, out_valid, busy, overrun} !== 28'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got %h, required 0", {bcd_quot, bcd_rem, err, out_valid, busy, overrun});
    end
    cycle();
    rst = 1'b0;
    repeat (5) cycle();
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_no_capture: busy/out_valid got %b, required 00", {busy, out_valid});
    end
    fire(201, 2, 1'b1, 1'b0);
    score("after_reset", 8);
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
